pgm_sched: RTL
==============

# pgm_sched

Packet-generation scheduler for the PGM stage. After a start command it replays a template packet from the 144×128 PGM RAM as back-to-back 134-bit words toward the next module (GOE), a configured number of times with a configured inter-packet gap. It honours downstream almost-full at packet boundaries and reports start/finish events and a sent-packet count. It owns the RAM read port only; the RAM write side and template loading are handled elsewhere.

## Interface
- RAM_AW, 7, RAM address width (128 entries)
- RAM_DW, 144, RAM word width; bits [133:0] carry packet data, [143:134] ignored
- PKT_DW, 134, output data width
- clk  in  1  sole clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_start  in  1  one-cycle pulse; begin generation
- cfg_stop  in  1  one-cycle pulse; stop after current packet
- cfg_pkt_words  in  7  words per packet; 0 means 128
- cfg_repeat  in  16  packets to send; 0 means continuous until stop
- cfg_gap  in  16  extra idle cycles between packets
- rd2ram_rd  out  1  RAM read enable
- rd2ram_raddr  out  7  RAM read address
- ram2rd_rdata  in  144  RAM read data, valid one cycle after read
- out_pgm_data  out  134  packet word
- out_pgm_data_wr  out  1  word strobe
- out_pgm_valid_wr  out  1  end-of-packet strobe
- out_pgm_valid  out  1  packet good flag; always 1 with valid_wr
- in_pgm_alf  in  1  downstream almost full
- pgm_sent_start_flag  out  1  pulse when start is accepted
- pgm_sent_finish_flag  out  1  pulse when generation ends
- pgm_busy  out  1  high in any state except IDLE
- pgm_sent_cnt  out  16  packets emitted since last start; wraps

## Operation
- States: IDLE, WAIT, READ, GAP.
- IDLE:
  - cfg_start latches words, repeat and gap, clears pgm_sent_cnt, pulses start_flag, and moves to WAIT.
  - cfg_stop is ignored.
- WAIT: if in_pgm_alf=0, go to READ with address 0; otherwise hold.
- READ:
  - Issue rd2ram_rd every cycle, address 0..words-1, with no stalls.
  - in_pgm_alf is not sampled inside a packet; alf guarantees room for one maximum packet.
  - After the last address, the next state depends on the packet count:
    - packet count reached (repeat≠0), or stop pending: go to IDLE.
    - otherwise, gap>0: go to GAP.
    - otherwise: go to WAIT.
- GAP: count gap cycles, then go to WAIT.
- Data path: out_pgm_data and out_pgm_data_wr are ram2rd_rdata[133:0] and rd2ram_rd delayed one cycle. RAM content, including header flag bits [133:132], passes through unmodified.
- End of packet: out_pgm_valid_wr=out_pgm_valid=1 in the same cycle as the last word's data_wr. pgm_sent_cnt increments in that cycle.
- Stop handling:
  - cfg_stop during READ is latched and takes effect at the packet end.
  - cfg_stop during WAIT or GAP goes to IDLE next cycle.
- Finish flag: pulses one cycle on every entry to IDLE from a non-IDLE state. When the entry follows a packet, the pulse coincides with the last word's valid_wr cycle + 0 (pipeline drain is counted).
- cfg_start while busy is ignored. Simultaneous start and stop in IDLE: start wins, and the stop is dropped.

## Timing
- Reset: all outputs 0, state IDLE, counters and latched config cleared.
- Start pulse at cycle 0 with alf=0:
  - WAIT at 1
  - first read at 2
  - first data_wr at 3
  - last data_wr at 2+words
- Gap between packets: last read at r, so last data_wr at r+1. The next first data_wr is at r+gap+3, giving gap+1 idle cycles (minimum 1).
- If alf is high in WAIT, the first read follows the cycle after alf is sampled low.
- Reset asserted mid-packet truncates the packet immediately with no valid_wr; downstream is reset in the same domain.
- pgm_sent_cnt wraps 0xFFFF→0 in continuous mode.

## Structure
- Shared package pgm_pkg:
  - RAM_AW/RAM_DW/PKT_DW constants
  - state encoding typedef (IDLE=0, WAIT=1, READ=2, GAP=3)
  - header flag codes (head 2'b01, mid 2'b11, tail 2'b10)
- Single flat module; no sub-module. Internal counters: word address (7 b), gap (16 b), repeat remaining (16 b).
- The RAM is instantiated by the parent.

## Test plan
- words=4, repeat=1, gap=0, alf=0:
  - reads at addresses 0..3 in cycles 2..5
  - data_wr in cycles 3..6
  - valid_wr at 6
  - finish_flag pulse, sent_cnt=1
- words=2, repeat=3, gap=2: three packets; each pair of packets separated by exactly 3 idle data_wr cycles; sent_cnt=3.
- words=0 (128), repeat=1: 128 consecutive data_wr; RAM address wraps 127 to end; data matches preloaded pattern.
- repeat=0, gap=0, alf toggled high for 10 cycles in mid-run:
  - no packet is truncated
  - the next packet starts only after alf=0
  - cfg_stop mid-packet ends the run after that packet's valid_wr
- cfg_start while busy and cfg_stop in IDLE are both ignored; cfg_stop in GAP returns to IDLE next cycle with finish pulse.
- rst_n asserted on the 3rd word of a 10-word packet: all outputs 0 immediately; after release the state is IDLE and sent_cnt=0.

Source files
------------

// File: rtl/pgm_pkg.sv
// Shared constants and encodings for the PGM packet-generation stage.
package pgm_pkg;

    localparam int RAM_AW = 7;
    localparam int RAM_DW = 144;
    localparam int PKT_DW = 134;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_READ = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Header flag codes carried in packet bits [133:132] of the template.
    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_MID  = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

endpackage

// File: rtl/pgm_sched.sv
// Replays a template packet from the PGM RAM N times with a programmable gap.
// Latency: start->first data_wr 3 cycles; RAM read->data_wr 1 cycle.
// Backpressure: in_pgm_alf is honoured only between packets; never stalls mid-packet.
module pgm_sched #(
    parameter int RAM_AW = pgm_pkg::RAM_AW,
    parameter int RAM_DW = pgm_pkg::RAM_DW,
    parameter int PKT_DW = pgm_pkg::PKT_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [RAM_AW-1:0] cfg_pkt_words,
    input  logic [15:0]       cfg_repeat,
    input  logic [15:0]       cfg_gap,
    output logic              rd2ram_rd,
    output logic [RAM_AW-1:0] rd2ram_raddr,
    input  logic [RAM_DW-1:0] ram2rd_rdata,
    output logic [PKT_DW-1:0] out_pgm_data,
    output logic              out_pgm_data_wr,
    output logic              out_pgm_valid_wr,
    output logic              out_pgm_valid,
    input  logic              in_pgm_alf,
    output logic              pgm_sent_start_flag,
    output logic              pgm_sent_finish_flag,
    output logic              pgm_busy,
    output logic [15:0]       pgm_sent_cnt
);

    pgm_pkg::state_t state_q, state_d;

    logic [RAM_AW-1:0] addr_q;
    logic [RAM_AW-1:0] words_q;
    logic [RAM_AW-1:0] last_idx;
    logic [15:0]       rep_q;
    logic [15:0]       rep_left_q;
    logic [15:0]       gap_q;
    logic [15:0]       gap_cnt_q;
    logic [15:0]       sent_cnt_q;
    logic              stop_pend_q;
    logic              rd_q;
    logic              eop_q;
    logic              start_flag_q;
    logic              finish_flag_q;

    logic              start_ok;
    logic              last_word;
    logic              pkt_end;
    logic              reps_done;
    logic              stop_now;
    logic              unused_rdata_hi;

    // words==0 encodes 128: the 7-bit subtraction wraps to 127 for free.
    assign last_idx  = words_q - {{(RAM_AW-1){1'b0}}, 1'b1};
    assign last_word = (addr_q == last_idx);
    assign start_ok  = (state_q == pgm_pkg::ST_IDLE) && cfg_start;
    assign pkt_end   = (state_q == pgm_pkg::ST_READ) && last_word;
    assign reps_done = (rep_q != 16'd0) && (rep_left_q == 16'd1);
    assign stop_now  = stop_pend_q || cfg_stop;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            pgm_pkg::ST_IDLE: if (cfg_start) state_d = pgm_pkg::ST_WAIT;
            pgm_pkg::ST_WAIT: begin
                if (cfg_stop)         state_d = pgm_pkg::ST_IDLE;
                else if (!in_pgm_alf) state_d = pgm_pkg::ST_READ;
            end
            pgm_pkg::ST_READ: begin
                if (last_word) begin
                    if (reps_done || stop_now) state_d = pgm_pkg::ST_IDLE;
                    else if (gap_q != 16'd0)   state_d = pgm_pkg::ST_GAP;
                    else                       state_d = pgm_pkg::ST_WAIT;
                end
            end
            pgm_pkg::ST_GAP: begin
                if (cfg_stop)                   state_d = pgm_pkg::ST_IDLE;
                else if (gap_cnt_q == 16'd1)    state_d = pgm_pkg::ST_WAIT;
            end
            default: state_d = pgm_pkg::ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= pgm_pkg::ST_IDLE;
            addr_q        <= '0;
            words_q       <= '0;
            rep_q         <= '0;
            rep_left_q    <= '0;
            gap_q         <= '0;
            gap_cnt_q     <= '0;
            sent_cnt_q    <= '0;
            stop_pend_q   <= 1'b0;
            rd_q          <= 1'b0;
            eop_q         <= 1'b0;
            start_flag_q  <= 1'b0;
            finish_flag_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_q          <= (state_q == pgm_pkg::ST_READ);
            eop_q         <= pkt_end;
            start_flag_q  <= start_ok;
            finish_flag_q <= (state_q != pgm_pkg::ST_IDLE) && (state_d == pgm_pkg::ST_IDLE);

            if (start_ok) begin
                words_q    <= cfg_pkt_words;
                rep_q      <= cfg_repeat;
                rep_left_q <= cfg_repeat;
                gap_q      <= cfg_gap;
                sent_cnt_q <= '0;
            end

            if (state_d == pgm_pkg::ST_IDLE)
                stop_pend_q <= 1'b0;
            else if ((state_q == pgm_pkg::ST_READ) && cfg_stop)
                stop_pend_q <= 1'b1;

            // Address sits at 0 outside READ so every packet starts from the template head.
            if (state_q == pgm_pkg::ST_READ) addr_q <= addr_q + 1'b1;
            else                             addr_q <= '0;

            if (pkt_end) begin
                sent_cnt_q <= sent_cnt_q + 16'd1;
                rep_left_q <= rep_left_q - 16'd1;
            end

            if (state_q == pgm_pkg::ST_GAP) gap_cnt_q <= gap_cnt_q - 16'd1;
            else                            gap_cnt_q <= gap_q;
        end
    end

    assign rd2ram_rd            = (state_q == pgm_pkg::ST_READ);
    assign rd2ram_raddr         = addr_q;
    assign out_pgm_data         = rd_q ? ram2rd_rdata[PKT_DW-1:0] : '0;
    assign out_pgm_data_wr      = rd_q;
    assign out_pgm_valid_wr     = eop_q;
    assign out_pgm_valid        = eop_q;
    assign pgm_sent_start_flag  = start_flag_q;
    assign pgm_sent_finish_flag = finish_flag_q;
    assign pgm_busy             = (state_q != pgm_pkg::ST_IDLE);
    assign pgm_sent_cnt         = sent_cnt_q;
    assign unused_rdata_hi      = ^ram2rd_rdata[RAM_DW-1:PKT_DW];

endmodule
